// File: rtl/i2c_slave_regbank.sv
// I2C slave fronting a local register bank: 8-bit pointer, auto-increment, burst read/write.
// SCL/SDA are oversampled on clk; START/STOP (incl. repeated START) are honoured in every state.
module i2c_slave_regbank #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned AW          = $clog2(NUM_REGS),
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          WRAP        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_idx,
  input  logic [7:0]            host_wdata,
  output logic                  wr_strobe,
  output logic [AW-1:0]         wr_idx,
  output logic [7:0]            wr_data,
  output logic                  rd_strobe,
  output logic                  busy,
  output logic                  selected,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, A_ACK, PTR, D_ACK, WDATA, RDATA, M_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [6:0]      shreg;
  logic [7:0]      byte_c;
  logic [AW-1:0]   ptr, ptr_nxt_c;
  logic            sat, rw, ack_on;
  logic [7:0]      tx;
  logic [7:0]      regs [NUM_REGS];

  // Bus synchroniser plus one edge-detect stage; idles high so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_c   = {shreg, sda_s};

  // Pointer advance: wrap to 0 or hold at the last register
  always_comb begin
    ptr_nxt_c = ptr + AW'(1);
    if (ptr == LAST_IDX) begin
      ptr_nxt_c = WRAP ? '0 : ptr;
    end
  end

  // Protocol FSM and register bank; the I2C commit is written after the host write so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sat       <= 1'b0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      tx        <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
      busy      <= 1'b0;
      selected  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;

      if (host_we && (32'(host_idx) < NUM_REGS)) regs[host_idx] <= host_wdata;

      if (start_c) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        busy     <= 1'b1;
        selected <= 1'b0;
      end else if (stop_c) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        selected <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: if (scl_rise) begin
            shreg   <= byte_c[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (byte_c[7:1] == DEV_ADDR) begin
                state    <= A_ACK;
                selected <= 1'b1;
                rw       <= byte_c[0];
                ack_on   <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end

          // First SCL fall drives ACK, second ends it and starts the data phase
          A_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              bit_cnt <= '0;
              if (rw) begin
                tx        <= regs[ptr];
                rd_strobe <= 1'b1;
                sda_oe    <= ~regs[ptr][7];
                state     <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end

          PTR: if (scl_rise) begin
            shreg   <= byte_c[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if ({1'b0, byte_c} >= 9'(NUM_REGS)) begin
                state    <= IDLE;
                selected <= 1'b0;
              end else begin
                ptr    <= AW'(byte_c);
                sat    <= 1'b0;
                ack_on <= 1'b0;
                state  <= D_ACK;
              end
            end
          end

          D_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end

          WDATA: if (scl_rise) begin
            shreg   <= byte_c[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (sat) begin
                state    <= IDLE;
                selected <= 1'b0;
              end else begin
                regs[ptr] <= byte_c;
                wr_strobe <= 1'b1;
                wr_idx    <= ptr;
                wr_data   <= byte_c;
                ptr       <= ptr_nxt_c;
                sat       <= !WRAP && (ptr == LAST_IDX);
                ack_on    <= 1'b0;
                state     <= D_ACK;
              end
            end
          end

          // Bit 7 was already presented when entering from A_ACK; later bits follow each fall
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= M_ACK;
              end else begin
                sda_oe <= ~tx[3'(4'd7 - bit_cnt)];
              end
            end
          end

          M_ACK: if (scl_rise) begin
            if (!sda_s) begin
              ptr       <= ptr_nxt_c;
              tx        <= regs[ptr_nxt_c];
              rd_strobe <= 1'b1;
              bit_cnt   <= '0;
              state     <= RDATA;
            end else begin
              state    <= IDLE;
              selected <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-level I2C master on a shared open-drain bus, two slaves
// (wrapping at 0x50, saturating at 0x52), checked against an array model of the bank and pointer.
module tb_i2c_slave_regbank;

  localparam int unsigned NR = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe0, sda_oe1;
  wire  sda_line = sda_m & ~sda_oe0 & ~sda_oe1;

  logic         host_we = 1'b0;
  logic [3:0]   host_idx = 4'd0;
  logic [7:0]   host_wdata = 8'd0;

  logic         wr_strobe0, rd_strobe0, busy0, selected0;
  logic [3:0]   wr_idx0;
  logic [7:0]   wr_data0;
  logic [NR*8-1:0] regs_flat0;

  logic         wr_strobe1, rd_strobe1, busy1, selected1;
  logic [3:0]   wr_idx1;
  logic [7:0]   wr_data1;
  logic [NR*8-1:0] regs_flat1;

  i2c_slave_regbank #(.NUM_REGS(16), .DEV_ADDR(7'h50), .SYNC_STAGES(2), .WRAP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe0),
    .host_we(host_we), .host_idx(host_idx), .host_wdata(host_wdata),
    .wr_strobe(wr_strobe0), .wr_idx(wr_idx0), .wr_data(wr_data0), .rd_strobe(rd_strobe0),
    .busy(busy0), .selected(selected0), .regs_flat(regs_flat0));

  i2c_slave_regbank #(.NUM_REGS(16), .DEV_ADDR(7'h52), .SYNC_STAGES(2), .WRAP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe1),
    .host_we(1'b0), .host_idx(4'd0), .host_wdata(8'd0),
    .wr_strobe(wr_strobe1), .wr_idx(wr_idx1), .wr_data(wr_data1), .rd_strobe(rd_strobe1),
    .busy(busy1), .selected(selected1), .regs_flat(regs_flat1));

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [NR];
  int         m_ptr = 0;

  logic [3:0] wr_idx_q [$];
  logic [7:0] wr_dat_q [$];
  int         rd_cnt0 = 0;
  int         wr_cnt1 = 0;
  logic       oe_seen = 1'b0;

  always @(posedge clk) begin
    if (wr_strobe0) begin
      wr_idx_q.push_back(wr_idx0);
      wr_dat_q.push_back(wr_data0);
    end
    if (rd_strobe0) rd_cnt0++;
    if (wr_strobe1) wr_cnt1++;
    if (sda_oe0 || sda_oe1) oe_seen = 1'b1;
  end

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  function automatic int nxt(input int p);
    return (p + 1) % NR;
  endfunction

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input int idx, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_idx = 4'(idx); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    m_regs[idx] = d;
  endtask

  task automatic i2c_start();
    wn(H/2);
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; wn(H/2);
      scl_m = 1'b1; wn(H/2);
    end
    sda_m = 1'b0; wn(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wn(H/2); sda_m = 1'b0;
    wn(H/2); scl_m = 1'b1;
    wn(H/2); sda_m = 1'b1;
    wn(H);
  endtask

  // Optional host write lands in the same clk as the slave's commit of this bit
  task automatic send_bit(input logic b, input bit coll, input logic [3:0] cidx, input logic [7:0] cdat);
    wn(H/2); sda_m = b;
    wn(H/2); scl_m = 1'b1;
    if (coll) begin
      wn(2);
      host_we = 1'b1; host_idx = cidx; host_wdata = cdat;
      wn(1);
      host_we = 1'b0;
      tests++;
      if (wr_strobe0 !== 1'b1) begin
        fails++;
        $display("FAIL coll_align: wr_strobe=%b want 1", wr_strobe0);
      end
      wn(H-3);
    end else begin
      wn(H);
    end
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wn(H/2); sda_m = 1'b1;
    wn(H/2); scl_m = 1'b1;
    wn(H/2); b = sda_line;
    wn(H/2); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit coll, input logic [3:0] cidx,
                           input logic [7:0] cdat, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], coll && (i == 0), cidx, cdat);
    recv_bit(ack);
  endtask

  task automatic send(input logic [7:0] d, output logic ack);
    send_byte(d, 1'b0, 4'd0, 8'd0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    rst_n = 1'b0;
    wn(4);
    tests++;
    if ({sda_oe0, busy0, selected0, wr_strobe0, rd_strobe0} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: oe/busy/sel/wr/rd=%b want 00000",
               {sda_oe0, busy0, selected0, wr_strobe0, rd_strobe0});
    end
    tests++;
    if ({wr_idx0, wr_data0} !== 12'h000) begin
      fails++;
      $display("FAIL reset_wr_bus: idx=%h data=%h want 0", wr_idx0, wr_data0);
    end
    tests++;
    if (regs_flat0 !== model_flat()) begin
      fails++;
      $display("FAIL reset_bank: got %h want %h", regs_flat0, model_flat());
    end
    rst_n = 1'b1;
    wn(4);
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2, a3;
    wr_idx_q.delete(); wr_dat_q.delete();
    i2c_start();
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL busy_start: got %b want 1", busy0); end
    send(8'hA0, a0);
    tests++;
    if (selected0 !== 1'b1) begin fails++; $display("FAIL selected: got %b want 1", selected0); end
    send(8'h03, a1); send(8'h11, a2); send(8'h22, a3);
    i2c_stop();
    m_regs[3] = 8'h11; m_regs[4] = 8'h22; m_ptr = 5;
    tests++;
    if ({a0, a1, a2, a3} !== 4'b0000) begin
      fails++; $display("FAIL write_acks: got %b want 0000", {a0, a1, a2, a3});
    end
    tests++;
    if (regs_flat0 !== model_flat()) begin
      fails++; $display("FAIL write_bank: got %h want %h", regs_flat0, model_flat());
    end
    tests++;
    if (!(wr_idx_q.size() == 2 && wr_idx_q[0] == 4'd3 && wr_idx_q[1] == 4'd4 &&
          wr_dat_q[0] == 8'h11 && wr_dat_q[1] == 8'h22)) begin
      fails++; $display("FAIL write_strobes: count=%0d want 2 (idx 3,4 data 11,22)", wr_idx_q.size());
    end
    tests++;
    if ({busy0, selected0} !== 2'b00) begin
      fails++; $display("FAIL busy_stop: busy/sel=%b want 00", {busy0, selected0});
    end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    oe_seen = 1'b0;
    i2c_start();
    send(8'hA2, a0);
    tests++;
    if (selected0 !== 1'b0) begin fails++; $display("FAIL wrong_sel: got %b want 0", selected0); end
    send(8'h77, a1);
    i2c_stop();
    tests++;
    if ({a0, a1} !== 2'b11) begin fails++; $display("FAIL wrong_nack: got %b want 11", {a0, a1}); end
    tests++;
    if (oe_seen !== 1'b0) begin fails++; $display("FAIL wrong_oe: sda_oe seen=%b want 0", oe_seen); end
    tests++;
    if (regs_flat0 !== model_flat()) begin
      fails++; $display("FAIL wrong_bank: got %h want %h", regs_flat0, model_flat());
    end
  endtask

  task automatic test_burst_read();
    logic a0, a1, a2, nk;
    logic [7:0] d, exp;
    int rd_base;
    host_wr(14, 8'($urandom)); host_wr(15, 8'($urandom)); host_wr(0, 8'($urandom));
    rd_base = rd_cnt0;
    i2c_start(); send(8'hA0, a0); send(8'h0E, a1); m_ptr = 14;
    i2c_start(); send(8'hA1, a2);
    tests++;
    if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL burst_acks: got %b want 000", {a0, a1, a2}); end
    for (int k = 0; k < 3; k++) begin
      nk = (k == 2);
      exp = m_regs[m_ptr];
      recv_byte(nk, d);
      if (k < 2) m_ptr = nxt(m_ptr);
      tests++;
      if (d !== exp) begin fails++; $display("FAIL burst_byte%0d: got %h want %h", k, d, exp); end
    end
    i2c_stop();
    tests++;
    if (rd_cnt0 - rd_base != 3) begin
      fails++; $display("FAIL burst_rd_strobes: got %0d want 3", rd_cnt0 - rd_base);
    end
  endtask

  task automatic test_ptr_oob();
    logic a0, a1;
    wr_idx_q.delete(); wr_dat_q.delete();
    i2c_start(); send(8'hA0, a0); send(8'h20, a1); i2c_stop();
    tests++;
    if ({a0, a1} !== 2'b01) begin fails++; $display("FAIL oob_acks: got %b want 01", {a0, a1}); end
    tests++;
    if (wr_idx_q.size() != 0) begin fails++; $display("FAIL oob_strobe: got %0d want 0", wr_idx_q.size()); end
  endtask

  task automatic test_wrap0();
    logic a0, a1, a2, a3;
    int wr_base;
    wr_base = wr_cnt1;
    i2c_start(); send(8'hA4, a0); send(8'h0F, a1); send(8'hAA, a2); send(8'hBB, a3);
    tests++;
    if (selected1 !== 1'b0) begin fails++; $display("FAIL sat_idle: selected=%b want 0", selected1); end
    i2c_stop();
    tests++;
    if ({a0, a1, a2, a3} !== 4'b0001) begin
      fails++; $display("FAIL sat_acks: got %b want 0001", {a0, a1, a2, a3});
    end
    tests++;
    if (regs_flat1[8*15 +: 8] !== 8'hAA) begin
      fails++; $display("FAIL sat_reg15: got %h want aa", regs_flat1[8*15 +: 8]);
    end
    tests++;
    if (wr_cnt1 - wr_base != 1) begin fails++; $display("FAIL sat_strobes: got %0d want 1", wr_cnt1 - wr_base); end
  endtask

  task automatic test_collision();
    logic a0, a1, a2, a3;
    logic [7:0] d4, h7;
    d4 = 8'($urandom); h7 = 8'($urandom);
    i2c_start(); send(8'hA0, a0); send(8'h03, a1);
    send_byte(8'h66, 1'b1, 4'd3, 8'h55, a2);
    send_byte(d4, 1'b1, 4'd7, h7, a3);
    i2c_stop();
    m_regs[3] = 8'h55; m_regs[3] = 8'h66;
    m_regs[7] = h7; m_regs[4] = d4; m_ptr = 5;
    tests++;
    if ({a0, a1, a2, a3} !== 4'b0000) begin
      fails++; $display("FAIL coll_acks: got %b want 0000", {a0, a1, a2, a3});
    end
    tests++;
    if (regs_flat0[8*3 +: 8] !== 8'h66) begin
      fails++; $display("FAIL coll_same_idx: reg3=%h want 66", regs_flat0[8*3 +: 8]);
    end
    tests++;
    if (regs_flat0 !== model_flat()) begin
      fails++; $display("FAIL coll_bank: got %h want %h", regs_flat0, model_flat());
    end
  endtask

  task automatic test_tx_hold();
    logic a0, a1, a2;
    logic [7:0] old_v, d;
    old_v = 8'($urandom);
    host_wr(9, old_v);
    i2c_start(); send(8'hA0, a0); send(8'h09, a1); m_ptr = 9;
    i2c_start(); send(8'hA1, a2);
    wn(6);
    host_wr(9, ~old_v);
    recv_byte(1'b1, d);
    i2c_stop();
    tests++;
    if (d !== old_v) begin fails++; $display("FAIL tx_hold: got %h want %h", d, old_v); end
    tests++;
    if (regs_flat0[8*9 +: 8] !== m_regs[9]) begin
      fails++; $display("FAIL tx_hold_bank: got %h want %h", regs_flat0[8*9 +: 8], m_regs[9]);
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2, b;
    logic [7:0] v, dn;
    v = 8'($urandom) & 8'hEF;
    host_wr(2, v);
    i2c_start(); send(8'hA0, a0); send(8'h02, a1);
    i2c_start(); send(8'hA1, a2);
    for (int i = 0; i < 3; i++) recv_bit(b);
    wn(H/2);
    tests++;
    if (sda_oe0 !== ~v[4]) begin fails++; $display("FAIL mid_bit4: sda_oe=%b want %b", sda_oe0, ~v[4]); end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    tests++;
    if ({sda_oe0, busy0} !== 2'b00) begin fails++; $display("FAIL mid_rst_oe: oe/busy=%b want 00", {sda_oe0, busy0}); end
    tests++;
    if (regs_flat0 !== model_flat()) begin fails++; $display("FAIL mid_rst_bank: got %h want 0", regs_flat0); end
    wn(2);
    rst_n = 1'b1;
    sda_m = 1'b1;
    dn = 8'($urandom);
    i2c_start(); send(8'hA0, a0); send(8'h01, a1); send(dn, a2); i2c_stop();
    m_regs[1] = dn; m_ptr = 2;
    tests++;
    if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL post_rst_acks: got %b want 000", {a0, a1, a2}); end
    tests++;
    if (regs_flat0 !== model_flat()) begin
      fails++; $display("FAIL post_rst_bank: got %h want %h", regs_flat0, model_flat());
    end
  endtask

  task automatic test_random();
    logic a, ack_or;
    logic [7:0] d, exp;
    int p, n;
    bit set_ptr;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) host_wr(int'($urandom_range(0, NR-1)), 8'($urandom));
      p = int'($urandom_range(0, NR-1));
      n = int'($urandom_range(1, 5));
      ack_or = 1'b0;
      i2c_start(); send(8'hA0, a); ack_or |= a;
      send(8'(p), a); ack_or |= a;
      m_ptr = p;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send(d, a); ack_or |= a;
        m_regs[m_ptr] = d;
        m_ptr = nxt(m_ptr);
      end
      set_ptr = ($urandom_range(0, 1) == 1);
      if (set_ptr) begin
        p = int'($urandom_range(0, NR-1));
        i2c_start(); send(8'hA0, a); ack_or |= a;
        send(8'(p), a); ack_or |= a;
        m_ptr = p;
      end else begin
        i2c_stop();
      end
      i2c_start(); send(8'hA1, a); ack_or |= a;
      tests++;
      if (ack_or !== 1'b0) begin fails++; $display("FAIL rnd%0d_acks: some NACK seen, want all ACK", it); end
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        exp = m_regs[m_ptr];
        recv_byte(k == n - 1, d);
        if (k < n - 1) m_ptr = nxt(m_ptr);
        tests++;
        if (d !== exp) begin fails++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, k, d, exp); end
      end
      i2c_stop();
      tests++;
      if (regs_flat0 !== model_flat()) begin
        fails++; $display("FAIL rnd%0d_bank: got %h want %h", it, regs_flat0, model_flat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_wrong_addr();
    test_burst_read();
    test_ptr_oob();
    test_wrap0();
    test_collision();
    test_tx_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
